// File: rtl/clmul_limb_sched.sv
// Purpose : builds the full carry-less product of two NLIMB*LIMB_W-bit operands by running
//           all NLIMB x NLIMB limb pairs through one shared external LIMB_W x LIMB_W clmul
//           core and XOR-accumulating each partial product at limb offset (i+j)*LIMB_W.
// Latency : NLIMB^2+1 cycles from the accept cycle to out_valid (17 by default); +1 with CLMUL_PIPE_EN.
// Backpr. : in_ready only in IDLE; the result is held on out_y until out_valid & out_ready.
//
// Build option: `define CLMUL_PIPE_EN registers mul_y before accumulation and adds a one-cycle
//               DRAIN state after MUL. Results are identical; only out_valid timing moves.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake; in_a/in_b captured on accept
//   mul_a/mul_b -> mul_y  limb operands to the shared combinational core and its product
//   out_valid/out_ready   result handshake; out_y = A*B over GF(2), 2*OPW-1 bits
module clmul_limb_sched #(
  parameter int LIMB_W = 18,
  parameter int NLIMB  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NLIMB*LIMB_W-1:0]       in_a,
  input  logic [NLIMB*LIMB_W-1:0]       in_b,
  output logic [LIMB_W-1:0]             mul_a,
  output logic [LIMB_W-1:0]             mul_b,
  input  logic [2*LIMB_W-2:0]           mul_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*NLIMB*LIMB_W-2:0]     out_y
);

  localparam int OPW = NLIMB * LIMB_W;
  localparam int PW  = 2 * LIMB_W - 1;
  localparam int YW  = 2 * OPW - 1;
  localparam int CW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   i_q, j_q;
  logic [OPW-1:0]  a_q, b_q;
  logic [YW-1:0]   acc_q;
  logic            last_step;
  logic            accept;

  // Accumulation term: what is XORed into the accumulator this cycle and where.
  logic            acc_en;
  logic [PW-1:0]   acc_val;
  logic [CW:0]     acc_off;

  assign last_step = (i_q == CW'(NLIMB - 1)) && (j_q == CW'(NLIMB - 1));
  assign accept    = in_valid && in_ready;
  assign out_y     = acc_q;

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_MUL;
      S_MUL: begin
        if (last_step) begin
`ifdef CLMUL_PIPE_EN
          state_d = S_DRAIN;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Limb select toward the shared core; quiet (zero) whenever not issuing a step.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state_q == S_MUL) begin
      mul_a = a_q[int'(i_q) * LIMB_W +: LIMB_W];
      mul_b = b_q[int'(j_q) * LIMB_W +: LIMB_W];
    end
  end

`ifdef CLMUL_PIPE_EN
  // Product of step k is registered here and folded in one cycle later, so the last
  // step of MUL lands during DRAIN.
  logic [PW-1:0] py_q;
  logic          pv_q;
  logic [CW:0]   po_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      py_q <= '0;
      pv_q <= 1'b0;
      po_q <= '0;
    end else begin
      py_q <= mul_y;
      pv_q <= (state_q == S_MUL);
      po_q <= {1'b0, i_q} + {1'b0, j_q};
    end
  end

  always_comb begin
    acc_en  = pv_q;
    acc_val = py_q;
    acc_off = po_q;
  end
`else
  always_comb begin
    acc_en  = (state_q == S_MUL);
    acc_val = mul_y;
    acc_off = {1'b0, i_q} + {1'b0, j_q};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        acc_q <= '0;
        i_q   <= '0;
        j_q   <= '0;
      end else begin
        // Highest offset is (2*NLIMB-2)*LIMB_W, whose PW-bit window ends exactly at bit YW-1.
        if (acc_en)
          acc_q[int'(acc_off) * LIMB_W +: PW] <= acc_q[int'(acc_off) * LIMB_W +: PW] ^ acc_val;
        if (state_q == S_MUL) begin
          if (last_step) begin
            i_q <= '0;
            j_q <= '0;
          end else if (j_q == CW'(NLIMB - 1)) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clmul_limb_sched.sv
// Bench for clmul_limb_sched: models the shared limb core, drives directed and random
// operand pairs with random output stalls, and compares against a bitwise GF(2) product.
module tb_clmul_limb_sched;

  localparam int LW  = 18;
  localparam int NL  = 4;
  localparam int OPW = NL * LW;
  localparam int YW  = 2 * OPW - 1;
`ifdef CLMUL_PIPE_EN
  localparam int LAT = NL * NL + 2;
`else
  localparam int LAT = NL * NL + 1;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_a, in_b;
  logic [LW-1:0]   mul_a, mul_b;
  logic [2*LW-2:0] mul_y;
  logic            out_valid;
  logic            out_ready;
  logic [YW-1:0]   out_y;

  int n_cmp = 0;
  int n_err = 0;

  clmul_limb_sched #(.LIMB_W(LW), .NLIMB(NL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*LW-2:0] clmul_limb(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [2*LW-2:0] r;
    r = '0;
    for (int k = 0; k < LW; k++)
      if (a[k]) r = r ^ ((2*LW-1)'(b) << k);
    return r;
  endfunction

  function automatic logic [YW-1:0] clmul_ref(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic [YW-1:0] r;
    r = '0;
    for (int k = 0; k < OPW; k++)
      if (a[k]) r = r ^ (YW'(b) << k);
    return r;
  endfunction

  // Shared combinational core seen by the scheduler
  always_comb mul_y = clmul_limb(mul_a, mul_b);

  task automatic check(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OPW-1:0] rand_op();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       return OPW'(1) << $urandom_range(0, OPW - 1);
      1:       return t[OPW-1:0] & {OPW{t[95]}};
      default: return t[OPW-1:0];
    endcase
  endfunction

  task automatic run_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input int max_stall);
    logic [YW-1:0] exp;
    int lat;
    int w;
    int st;
    exp = clmul_ref(a, b);
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_idle", YW'(in_ready), YW'(1));
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = $urandom_range(0, 1);   // ignored while busy
    in_a     = rand_op();              // operands were captured
    in_b     = rand_op();
    check("in_ready_busy", YW'(in_ready), YW'(0));
    lat = 1;
    while (!out_valid && lat < 64) begin
      out_ready = $urandom_range(0, 1); // no effect without out_valid
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    check("latency", YW'(lat), YW'(LAT));
    out_ready = 1'b0;
    st = $urandom_range(0, max_stall);
    repeat (st) begin
      @(posedge clk); #1;
      check("stall_y", out_y, exp);
      check("stall_vld", YW'(out_valid), YW'(1));
      check("stall_in_rdy", YW'(in_ready), YW'(0));
    end
    check("out_y", out_y, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("vld_drop", YW'(out_valid), YW'(0));
  endtask

  initial begin
    logic [OPW-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", YW'(in_ready), YW'(1));
    check("rst_out_valid", YW'(out_valid), YW'(0));
    check("rst_out_y", out_y, '0);
    check("rst_mul_a", YW'(mul_a), '0);
    check("rst_mul_b", YW'(mul_b), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(OPW'(1), OPW'(1), 2);
    run_op(OPW'(3), OPW'(3), 2);
    run_op(OPW'(1) << 71, OPW'(1) << 71, 2);
    run_op(OPW'(1) << 17, OPW'(1) << 18, 2);
    run_op({OPW{1'b1}}, {OPW{1'b1}}, 2);

    // Random operands with random output stalls
    for (int n = 0; n < 1000; n++) begin
      ra = rand_op();
      rb = rand_op();
      run_op(ra, rb, 3);
    end

    // Reset in the middle of MUL, step 8
    ra = {$urandom(), $urandom(), $urandom()} | OPW'(1) << 40;
    in_valid = 1'b1;
    in_a     = ra;
    in_b     = {OPW{1'b1}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", YW'(in_ready), YW'(1));
    check("mid_rst_out_valid", YW'(out_valid), YW'(0));
    check("mid_rst_out_y", out_y, '0);
    check("mid_rst_mul_a", YW'(mul_a), '0);
    check("mid_rst_mul_b", YW'(mul_b), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", YW'(in_ready), YW'(1));
    run_op(OPW'(3), OPW'(5), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
